// File: rtl/crossbar_allocator_pkg.sv
// Shared allocation types for the crossbar allocator and crossbar_if users.
// Pure type definitions: no latency, no backpressure.
package crossbar_allocator_pkg;
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;
endpackage

// File: rtl/crossbar_allocator_rr_arbiter.sv
// Round-robin pick: first requester strictly after ptr, wrapping N-1 -> 0.
// Combinational, zero latency; no backpressure (pure function of req/ptr).
module crossbar_allocator_rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N) + (N == 1)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          vld
);
    logic [IW-1:0] cand;

    // Scan farthest-first so the nearest candidate after ptr is the last write.
    always_comb begin
        idx  = '0;
        vld  = 1'b0;
        cand = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                idx = cand;
                vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/crossbar_allocator.sv
// Per-output round-robin crossbar allocation with packet locking; 1-cycle alloc, then 1 flit/cycle.
// Backpressure: out_ready low or owner valid low stalls the locked output (lock kept).
// CROSSBAR_ALLOC_WATCHDOG_EN adds a per-output stall watchdog that breaks the lock.
module crossbar_allocator
    import crossbar_allocator_pkg::*;
#(
    parameter  int NUM_IN          = 4,
    parameter  int NUM_OUT         = 4,
    parameter  int WATCHDOG_CYCLES = 64,
    localparam int SELECT_SIZE     = $clog2(NUM_IN) + (NUM_IN == 1),
    localparam int DEST_SIZE       = $clog2(NUM_OUT) + (NUM_OUT == 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_IN-1:0]                    req_valid,
    input  logic [NUM_IN-1:0][DEST_SIZE-1:0]     req_dest,
    input  logic [NUM_IN-1:0]                    req_last,
    input  logic [NUM_OUT-1:0]                   out_ready,
    output logic [NUM_IN-1:0]                    grant,
    output logic [NUM_OUT-1:0][SELECT_SIZE-1:0]  sel,
    output logic [NUM_OUT-1:0]                   enable,
    output logic [NUM_OUT-1:0]                   wd_err
);
    if (WATCHDOG_CYCLES < 2) begin : g_wd_cfg_check
        $error("WATCHDOG_CYCLES must be at least 2");
    end

    alloc_state_t                     state_q [NUM_OUT];
    alloc_state_t                     state_d [NUM_OUT];
    logic         [SELECT_SIZE-1:0]   owner_q [NUM_OUT];
    logic         [SELECT_SIZE-1:0]   owner_d [NUM_OUT];
    logic         [SELECT_SIZE-1:0]   ptr_q   [NUM_OUT];
    logic         [SELECT_SIZE-1:0]   ptr_d   [NUM_OUT];
    logic         [NUM_IN-1:0]        cand    [NUM_OUT];
    logic         [SELECT_SIZE-1:0]   arb_idx [NUM_OUT];
    logic         [NUM_OUT-1:0]       arb_vld;
    logic         [NUM_OUT-1:0]       fire;

`ifdef CROSSBAR_ALLOC_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES) + 1;
    logic [WD_W-1:0] wd_cnt_q [NUM_OUT];
    logic [WD_W-1:0] wd_cnt_d [NUM_OUT];
`else
    assign wd_err = '0;
`endif

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
        always_comb begin
            cand[o] = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                cand[o][i] = req_valid[i] && (req_dest[i] == DEST_SIZE'(o));
            end
        end

        crossbar_allocator_rr_arbiter #(.N(NUM_IN)) u_arb (
            .req (cand[o]),
            .ptr (ptr_q[o]),
            .idx (arb_idx[o]),
            .vld (arb_vld[o])
        );

        // sel only changes on allocation, so it holds steady through idle bubbles.
        assign sel[o] = (NUM_IN == 1) ? '0 : owner_q[o];

        a_owner_dest_stable: assert property (@(posedge clk) disable iff (rst)
            (state_q[o] == LOCKED && req_valid[owner_q[o]])
                |-> (req_dest[owner_q[o]] == DEST_SIZE'(o)));
    end

    always_comb begin
        grant  = '0;
        enable = '0;
        fire   = '0;
`ifdef CROSSBAR_ALLOC_WATCHDOG_EN
        wd_err = '0;
`endif
        for (int o = 0; o < NUM_OUT; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            fire[o]    = (state_q[o] == LOCKED) && req_valid[owner_q[o]]
                       && (req_dest[owner_q[o]] == DEST_SIZE'(o)) && out_ready[o];
            enable[o]  = fire[o];
            if (fire[o]) begin
                grant[owner_q[o]] = 1'b1;
            end
            case (state_q[o])
                IDLE: begin
                    if (arb_vld[o]) begin
                        owner_d[o] = arb_idx[o];
                        state_d[o] = LOCKED;
                    end
                end
                LOCKED: begin
                    if (fire[o] && req_last[owner_q[o]]) begin
                        state_d[o] = IDLE;
                        ptr_d[o]   = owner_q[o];
                    end
                end
                default: state_d[o] = IDLE;
            endcase
`ifdef CROSSBAR_ALLOC_WATCHDOG_EN
            wd_cnt_d[o] = '0;
            if (state_q[o] == LOCKED && !fire[o]) begin
                if (wd_cnt_q[o] == WD_W'(WATCHDOG_CYCLES - 1)) begin
                    state_d[o] = IDLE;
                    ptr_d[o]   = owner_q[o];
                    wd_err[o]  = 1'b1;
                end else begin
                    wd_cnt_d[o] = wd_cnt_q[o] + 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NUM_OUT; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= SELECT_SIZE'(NUM_IN - 1);
`ifdef CROSSBAR_ALLOC_WATCHDOG_EN
                wd_cnt_q[o] <= '0;
`endif
            end
        end else begin
            for (int o = 0; o < NUM_OUT; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
`ifdef CROSSBAR_ALLOC_WATCHDOG_EN
                wd_cnt_q[o] <= wd_cnt_d[o];
`endif
            end
        end
    end
endmodule
